synth_bus_arbiter: RTL



---
 rtl/synth_bus_pkg.sv | 40 ++++
 rtl/synth_bus_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/synth_bus_pkg.sv
// synth_bus_pkg: shared types and constants for the synth parameter bus arbiter.
`default_nettype none

package synth_bus_pkg;

  localparam int DEFAULT_ADR_W = 7;
  localparam int SEL_W         = 5;

  localparam int SEL_ENV = 0;
  localparam int SEL_OSC = 1;
  localparam int SEL_M1  = 2;
  localparam int SEL_M2  = 3;
  localparam int SEL_COM = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_TURN   = 3'd5
  } state_t;

  // The address field width bounds the arbiter's ADR_W parameter.
  typedef struct packed {
    logic [DEFAULT_ADR_W-1:0] adr;
    logic [SEL_W-1:0]         sel;
    logic                     read;
    logic                     write;
    logic [7:0]               wdata;
  } cmd_t;

  // A command with both kinds set is a write.
  function automatic logic is_read_cmd(input cmd_t c);
    return c.read && !c.write;
  endfunction

endpackage

`default_nettype wire

// File: rtl/synth_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | synth_bus_arbiter: request/grant arbiter for the synth parameter bus,     |
// | MIDI decoder vs CPU, sequenced single access. Option macro:              |
// | SYNTH_BUS_ARB_FAIRNESS_EN enables the CPU starvation override.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module synth_bus_arbiter
  import synth_bus_pkg::*;
#(
  parameter int ADR_W       = DEFAULT_ADR_W,
  parameter int RD_LAT      = 2,
  parameter int HOLD_CYCLES = 5,
  parameter int STARVE_MAX  = 8
) (
  input  logic             CLOCK_25,
  input  logic             reset,
  input  logic             dec_req,
  input  logic [ADR_W-1:0] dec_adr,
  input  logic [4:0]       dec_sel,
  input  logic             dec_read,
  input  logic             dec_write,
  input  logic [7:0]       dec_wdata,
  output logic             dec_gnt,
  output logic             dec_done,
  input  logic             cpu_req,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [4:0]       cpu_sel,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [7:0]       cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_done,
  output logic [7:0]       rdata,
  output logic [ADR_W-1:0] bus_adr,
  output logic [4:0]       bus_sel,
  output logic             bus_read,
  output logic             bus_write,
  output logic [7:0]       bus_wdata,
  input  logic [7:0]       bus_rdata,
  output logic             bus_busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 2);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t           state, state_next;
  cmd_t             cmd, cmd_next, dec_cmd, cpu_cmd;
  logic             win_cpu, win_cpu_next;
  logic [3:0]       cnt, cnt_next;
  logic             rdata_load;
  logic             cpu_wins;

  logic             gnt_d, dec_gnt_d, cpu_gnt_d, dec_done_d, cpu_done_d;
  logic             bus_read_d, bus_write_d, bus_busy_d;
  logic [ADR_W-1:0] bus_adr_d;
  logic [4:0]       bus_sel_d;
  logic [7:0]       bus_wdata_d;

  assign dec_cmd = '{adr: DEFAULT_ADR_W'(dec_adr), sel: dec_sel, read: dec_read,
                     write: dec_write, wdata: dec_wdata};
  assign cpu_cmd = '{adr: DEFAULT_ADR_W'(cpu_adr), sel: cpu_sel, read: cpu_read,
                     write: cpu_write, wdata: cpu_wdata};

`ifdef SYNTH_BUS_ARB_FAIRNESS_EN
  localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;

  assign cpu_wins = cpu_req && (!dec_req || (starve_cnt == STARVE_TOP));

  // Counts decoder wins that left a pending CPU request behind.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if ((state == ST_IDLE) && (dec_req || cpu_req)) begin
      if (cpu_wins || !cpu_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_TOP) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end
`else
  assign cpu_wins = cpu_req && !dec_req;
`endif

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd       <= '0;
      win_cpu   <= 1'b0;
      cnt       <= '0;
      dec_gnt   <= 1'b0;
      cpu_gnt   <= 1'b0;
      dec_done  <= 1'b0;
      cpu_done  <= 1'b0;
      rdata     <= '0;
      bus_adr   <= '0;
      bus_sel   <= '0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_wdata <= '0;
      bus_busy  <= 1'b0;
    end else begin
      state     <= state_next;
      cmd       <= cmd_next;
      win_cpu   <= win_cpu_next;
      cnt       <= cnt_next;
      dec_gnt   <= dec_gnt_d;
      cpu_gnt   <= cpu_gnt_d;
      dec_done  <= dec_done_d;
      cpu_done  <= cpu_done_d;
      bus_adr   <= bus_adr_d;
      bus_sel   <= bus_sel_d;
      bus_read  <= bus_read_d;
      bus_write <= bus_write_d;
      bus_wdata <= bus_wdata_d;
      bus_busy  <= bus_busy_d;
      if (rdata_load) begin
        rdata <= bus_rdata;
      end
    end
  end

  // One counter serves both the read wait and the turnaround hold.
  always_comb begin
    state_next   = state;
    cmd_next     = cmd;
    win_cpu_next = win_cpu;
    cnt_next     = cnt;
    rdata_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dec_req || cpu_req) begin
          state_next   = ST_SETUP;
          win_cpu_next = cpu_wins;
          cmd_next     = cpu_wins ? cpu_cmd : dec_cmd;
        end
      end
      ST_SETUP: state_next = ST_STROBE;
      ST_STROBE: begin
        if (is_read_cmd(cmd)) begin
          if (RD_LAT == 1) begin
            rdata_load = 1'b1;
            state_next = ST_DONE;
          end else begin
            cnt_next   = WAIT_LOAD;
            state_next = ST_WAIT;
          end
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          rdata_load = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        if (HOLD_CYCLES == 0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next   = HOLD_LOAD;
          state_next = ST_TURN;
        end
      end
      ST_TURN: begin
        if (cnt == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    gnt_d       = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                  (state_next == ST_WAIT)  || (state_next == ST_DONE);
    dec_gnt_d   = gnt_d && !win_cpu_next;
    cpu_gnt_d   = gnt_d && win_cpu_next;
    dec_done_d  = (state_next == ST_DONE) && !win_cpu_next;
    cpu_done_d  = (state_next == ST_DONE) && win_cpu_next;
    bus_sel_d   = gnt_d ? cmd_next.sel : 5'd0;
    bus_adr_d   = gnt_d ? ADR_W'(cmd_next.adr) : bus_adr;
    bus_wdata_d = gnt_d ? cmd_next.wdata : bus_wdata;
    bus_write_d = (state_next == ST_STROBE) && cmd_next.write;
    bus_read_d  = ((state_next == ST_STROBE) || (state_next == ST_WAIT)) &&
                  is_read_cmd(cmd_next);
    bus_busy_d  = (state_next != ST_IDLE);
  end

endmodule

`default_nettype wire
